// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation controller.
package rsa_pkg;

  localparam int DATA_W          = 13;
  localparam int MOD_LIMIT_DEF   = 256;
  localparam int MOD_CNT_W_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_E,
    LOAD_N,
    INIT,
    INIT_WAIT,
    MOD,
    MUL,
    DONE
  } state_t;

  localparam logic [1:0] CMD_ENCRYPT = 2'd0;
  localparam logic [1:0] CMD_LOAD_E  = 2'd1;
  localparam logic [1:0] CMD_LOAD_N  = 2'd2;

endpackage

// File: rtl/rsa_mod_watchdog.sv
// Counts consecutive subtract cycles within one reduction and flags a runaway.
module rsa_mod_watchdog
  import rsa_pkg::*;
#(
  parameter int LIMIT = MOD_LIMIT_DEF,
  parameter int CNT_W = MOD_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

  // High while the pending increment would bring the count to LIMIT.
  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rsa_controller.sv
// Command sequencer for the RSA datapath: loads e/n and runs square-and-reduce encryption.
module rsa_controller
  import rsa_pkg::*;
#(
  parameter int MOD_LIMIT = MOD_LIMIT_DEF,
  parameter int CNT_W     = MOD_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              is_init_done,
  input  logic              is_multiplication_done,
  input  logic              is_mod_done,
  output logic              initialize,
  output logic              en_multiply,
  output logic              en_modulo,
  output logic              update_e,
  output logic              update_n,
  output logic              done,
  output logic              busy,
  output logic              result_valid,
  output logic              error
);

  state_t state_q, state_d;
  logic   rv_q, rv_d;
  logic   err_q, err_d;
  logic   e_zero_q, e_zero_d;
  logic   n_zero_q, n_zero_d;
  logic   wd_expired;

  rsa_mod_watchdog #(
    .LIMIT (MOD_LIMIT),
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != MOD),
    .inc     (state_q == MOD && !is_mod_done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      e_zero_q <= 1'b0;
      n_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      e_zero_q <= e_zero_d;
      n_zero_q <= n_zero_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rv_d        = rv_q;
    err_d       = err_q;
    e_zero_d    = e_zero_q;
    n_zero_d    = n_zero_q;
    initialize  = 1'b0;
    en_multiply = 1'b0;
    en_modulo   = 1'b0;
    update_e    = 1'b0;
    update_n    = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rv_d = 1'b0;
          case (cmd)
            CMD_LOAD_E: begin
              state_d = LOAD_E;
              err_d   = 1'b0;
            end
            CMD_LOAD_N: begin
              state_d = LOAD_N;
              err_d   = 1'b0;
            end
            CMD_ENCRYPT: begin
              // A zero exponent or modulus would never terminate the datapath loop.
              if (e_zero_q || n_zero_q) begin
                err_d = 1'b1;
              end else begin
                state_d = INIT;
                err_d   = 1'b0;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      LOAD_E: begin
        update_e = 1'b1;
        e_zero_d = (data == '0);
        state_d  = IDLE;
      end
      LOAD_N: begin
        update_n = 1'b1;
        n_zero_d = (data == '0);
        state_d  = IDLE;
      end
      INIT: begin
        initialize = 1'b1;
        state_d    = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (is_init_done) state_d = MOD;
      end
      MOD: begin
        en_modulo = !is_mod_done;
        if (is_mod_done) begin
          state_d = is_multiplication_done ? DONE : MUL;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      MUL: begin
        en_multiply = 1'b1;
        state_d     = MOD;
      end
      DONE: begin
        done    = 1'b1;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = rv_q;
  assign error        = err_q;

endmodule
